// File: rtl/msx_mouse_pkg.sv
// Shared types for the MSX joystick-port mouse reader.
// CNT_W sizes the settle counter for the largest legal SETTLE value.
package msx_mouse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] nib_idx_t;

  localparam int CNT_W = $clog2(4096);

endpackage

// File: rtl/msx_mouse_reader_sync_ff.sv
// Two-flop synchronizer for signals arriving asynchronously to clk.
// Both stages reset to 0.
module sync_ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/msx_mouse_reader.sv
// Host-side MSX mouse reader: toggles the port strobe four times per start
// and assembles X/Y deltas and buttons from the returned nibbles.
module msx_mouse_reader
  import msx_mouse_pkg::*;
#(
  parameter int SETTLE = 64
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] data,
  output logic       strobe,
  output logic       busy,
  output logic       valid,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] buttons
);

  if (SETTLE < 3 || SETTLE > 4095) begin : g_bad_settle
    $error("msx_mouse_reader: SETTLE must be within 3..4095");
  end

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  logic [5:0]       w_data_sync;
  logic             w_cnt_zero;
  logic             w_last_nib;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  nib_idx_t         r_idx;
  logic [3:0]       r_nib [4];
  logic [1:0]       r_btn_cap;
  logic             r_strobe;
  logic             r_busy;
  logic             r_valid;
  logic [7:0]       r_dx;
  logic [7:0]       r_dy;
  logic [1:0]       r_buttons;

  sync_ff #(
    .W (6)
  ) u_data_sync (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .i_d   (data),
    .o_q   (w_data_sync)
  );

  assign w_cnt_zero = (r_cnt == '0);
  assign w_last_nib = (r_idx == nib_idx_t'(3));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_nib[0]  <= '0;
      r_nib[1]  <= '0;
      r_nib[2]  <= '0;
      r_nib[3]  <= '0;
      r_btn_cap <= '0;
      r_strobe  <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_buttons <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_strobe <= ~r_strobe;
            r_cnt    <= RELOAD;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (w_cnt_zero) begin
            r_nib[r_idx] <= w_data_sync[3:0];
            if (w_last_nib) begin
              // Buttons are active-low on the pins; stored as 1 = pressed.
              r_btn_cap <= ~w_data_sync[5:4];
              r_state   <= DONE;
            end else begin
              r_strobe <= ~r_strobe;
              r_cnt    <= RELOAD;
              r_idx    <= r_idx + nib_idx_t'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          r_dx      <= {r_nib[0], r_nib[1]};
          r_dy      <= {r_nib[2], r_nib[3]};
          r_buttons <= r_btn_cap;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign strobe  = r_strobe;
  assign busy    = r_busy;
  assign valid   = r_valid;
  assign dx      = r_dx;
  assign dy      = r_dy;
  assign buttons = r_buttons;

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Directed bench for msx_mouse_reader: a SETTLE=64 instance and a SETTLE=3
// instance, each driven by a strobe-toggled mouse responder model.
module tb_msx_mouse_reader;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;

  logic       start_a = 1'b0;
  logic [5:0] data_a  = 6'h3F;
  logic       strobe_a, busy_a, valid_a;
  logic [7:0] dx_a, dy_a;
  logic [1:0] buttons_a;

  logic       start_b = 1'b0;
  logic [5:0] data_b  = 6'h3F;
  logic       strobe_b, busy_b, valid_b;
  logic [7:0] dx_b, dy_b;
  logic [1:0] buttons_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int e0;

  always #5 clk_sys = ~clk_sys;

  msx_mouse_reader #(.SETTLE(64)) dut_a (
    .clk_sys (clk_sys), .reset_n (reset_n), .start (start_a), .data (data_a),
    .strobe (strobe_a), .busy (busy_a), .valid (valid_a),
    .dx (dx_a), .dy (dy_a), .buttons (buttons_a)
  );

  msx_mouse_reader #(.SETTLE(3)) dut_b (
    .clk_sys (clk_sys), .reset_n (reset_n), .start (start_b), .data (data_b),
    .strobe (strobe_b), .busy (busy_b), .valid (valid_b),
    .dx (dx_b), .dy (dy_b), .buttons (buttons_b)
  );

  // Responder packets: nibbles {Xhi, Xlo, Yhi, Ylo} and raw (active-low) button pins.
  logic [15:0] pkt_a [0:7] = '{16'h05FD, 16'h1234, 16'hFF80, 16'h7F01,
                               16'hABCD, 16'h9999, 16'h3CE2, 16'h0000};
  logic [1:0]  pin_a [0:7] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00};
  logic [15:0] pkt_b [0:3] = '{16'h817E, 16'h2D4B, 16'h0000, 16'h0000};
  logic [1:0]  pin_b [0:3] = '{2'b11, 2'b10, 2'b00, 2'b00};

  // Hand-computed expected results per packet of instance A.
  logic [7:0] exp_dx_a  [0:6] = '{8'h05, 8'h12, 8'hFF, 8'h7F, 8'hAB, 8'h00, 8'h3C};
  logic [7:0] exp_dy_a  [0:6] = '{8'hFD, 8'h34, 8'h80, 8'h01, 8'hCD, 8'h00, 8'hE2};
  logic [1:0] exp_btn_a [0:6] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10};

  int m_idx_a = 0, m_rd_a = 0, m_idle_a = 0;
  int m_idx_b = 0, m_rd_b = 0, m_idle_b = 0;
  logic m_prev_a = 1'b0, m_prev_b = 1'b0;

  // Responder: present the next nibble right after every strobe edge;
  // an idle strobe for longer than the timeout restarts the packet.
  always @(posedge clk_sys) begin
    logic [15:0] t;
    #1;
    if (strobe_a !== m_prev_a) begin
      t = pkt_a[m_rd_a];
      data_a = {pin_a[m_rd_a], t[4*(3-m_idx_a) +: 4]};
      if (m_idx_a == 3) begin m_idx_a = 0; m_rd_a++; end
      else m_idx_a++;
      m_idle_a = 0;
    end else if (m_idle_a < 300) begin
      m_idle_a++;
    end else if (m_idx_a != 0) begin
      m_idx_a = 0;
      m_rd_a++;
    end
    m_prev_a = strobe_a;

    if (strobe_b !== m_prev_b) begin
      t = pkt_b[m_rd_b];
      data_b = {pin_b[m_rd_b], t[4*(3-m_idx_b) +: 4]};
      if (m_idx_b == 3) begin m_idx_b = 0; m_rd_b++; end
      else m_idx_b++;
      m_idle_b = 0;
    end else if (m_idle_b < 20) begin
      m_idle_b++;
    end else if (m_idx_b != 0) begin
      m_idx_b = 0;
      m_rd_b++;
    end
    m_prev_b = strobe_b;
  end

  int tog_a[$], val_a[$], tog_b[$], val_b[$];
  logic [7:0] dxq_a[$], dyq_a[$], dxq_b[$], dyq_b[$];
  logic [1:0] btq_a[$], btq_b[$];
  logic mon_prev_a = 1'b0, mon_prev_b = 1'b0;

  // Edge counter plus event log of strobe toggles and valid pulses.
  always @(posedge clk_sys) begin
    cyc++;
    #2;
    if (strobe_a !== mon_prev_a) tog_a.push_back(cyc);
    mon_prev_a = strobe_a;
    if (valid_a) begin
      val_a.push_back(cyc); dxq_a.push_back(dx_a); dyq_a.push_back(dy_a); btq_a.push_back(buttons_a);
    end
    if (strobe_b !== mon_prev_b) tog_b.push_back(cyc);
    mon_prev_b = strobe_b;
    if (valid_b) begin
      val_b.push_back(cyc); dxq_b.push_back(dx_b); dyq_b.push_back(dy_b); btq_b.push_back(buttons_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clear_logs();
    tog_a.delete(); val_a.delete(); dxq_a.delete(); dyq_a.delete(); btq_a.delete();
    tog_b.delete(); val_b.delete(); dxq_b.delete(); dyq_b.delete(); btq_b.delete();
  endtask

  task automatic wait_valid(input int sel, input int n, input int budget);
    int i = 0;
    while (i < budget && ((sel == 0) ? val_a.size() : val_b.size()) < n) begin
      @(negedge clk_sys);
      i++;
    end
    check("valid_count_in_budget", (sel == 0) ? val_a.size() : val_b.size(), n);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk_sys);
  endtask

  task automatic pulse_start_a();
    @(negedge clk_sys) start_a = 1'b1;
    @(negedge clk_sys) start_a = 1'b0;
    e0 = cyc;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_strobe", strobe_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_dx", dx_a, 0);
    check("rst_dy", dy_a, 0);
    check("rst_buttons", buttons_a, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Single read: timing of toggles, valid and busy; packet 0
    clear_logs();
    pulse_start_a();
    check("r1_busy_after_start", busy_a, 1);
    wait_cyc(e0 + 256);
    check("r1_busy_at_256", busy_a, 1);
    check("r1_valid_at_256", valid_a, 0);
    @(negedge clk_sys);
    check("r1_busy_at_257", busy_a, 0);
    check("r1_valid_at_257", valid_a, 1);
    wait_valid(0, 1, 50);
    repeat (3) @(negedge clk_sys);
    check("r1_toggle_count", tog_a.size(), 4);
    for (int k = 0; k < 4; k++) check($sformatf("r1_toggle%0d_edge", k), tog_a[k] - e0, 64 * k);
    check("r1_valid_edge", val_a[0] - e0, 257);
    check("r1_dx", dx_a, exp_dx_a[0]);
    check("r1_dy", dy_a, exp_dy_a[0]);
    check("r1_buttons", buttons_a, exp_btn_a[0]);
    check("r1_strobe_end", strobe_a, 0);

    // Back-to-back: start held high for three reads; packets 1..3
    clear_logs();
    @(negedge clk_sys) start_a = 1'b1;
    @(negedge clk_sys) e0 = cyc;
    wait_cyc(e0 + 516);
    start_a = 1'b0;
    wait_valid(0, 3, 1000);
    repeat (5) @(negedge clk_sys);
    check("b2b_toggle_count", tog_a.size(), 12);
    for (int r = 0; r < 3; r++) begin
      check($sformatf("b2b%0d_start_edge", r), tog_a[4*r] - e0, 258 * r);
      check($sformatf("b2b%0d_valid_edge", r), val_a[r] - e0, 258 * r + 257);
      check($sformatf("b2b%0d_dx", r), dxq_a[r], exp_dx_a[r+1]);
      check($sformatf("b2b%0d_dy", r), dyq_a[r], exp_dy_a[r+1]);
      check($sformatf("b2b%0d_buttons", r), btq_a[r], exp_btn_a[r+1]);
    end
    check("b2b_strobe_end", strobe_a, 0);

    // Start while busy is ignored; packet 4
    clear_logs();
    pulse_start_a();
    wait_cyc(e0 + 99);
    start_a = 1'b1;
    @(negedge clk_sys) start_a = 1'b0;
    wait_cyc(e0 + 600);
    check("ign_toggle_count", tog_a.size(), 4);
    check("ign_valid_count", val_a.size(), 1);
    check("ign_dx", dx_a, exp_dx_a[4]);
    check("ign_dy", dy_a, exp_dy_a[4]);
    check("ign_buttons", buttons_a, exp_btn_a[4]);

    // Reset mid-read after three toggles; packet 5 is discarded
    clear_logs();
    pulse_start_a();
    wait_cyc(e0 + 149);
    check("mid_strobe_before_rst", strobe_a, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_strobe", strobe_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_dx", dx_a, 0);
    check("mid_rst_dy", dy_a, 0);
    check("mid_rst_buttons", buttons_a, 0);
    @(negedge clk_sys) reset_n = 1'b1;
    repeat (400) @(negedge clk_sys);
    clear_logs();
    pulse_start_a();
    wait_valid(0, 1, 400);
    repeat (2) @(negedge clk_sys);
    check("post_rst_toggle_count", tog_a.size(), 4);
    check("post_rst_dx", dx_a, exp_dx_a[6]);
    check("post_rst_dy", dy_a, exp_dy_a[6]);
    check("post_rst_buttons", buttons_a, exp_btn_a[6]);

    // SETTLE=3 instance: minimum settle, two back-to-back reads
    clear_logs();
    @(negedge clk_sys) start_b = 1'b1;
    @(negedge clk_sys) e0 = cyc;
    wait_cyc(e0 + 14);
    start_b = 1'b0;
    wait_valid(1, 2, 100);
    repeat (5) @(negedge clk_sys);
    check("s3_toggle_count", tog_b.size(), 8);
    for (int k = 0; k < 4; k++) check($sformatf("s3_toggle%0d_edge", k), tog_b[k] - e0, 3 * k);
    check("s3_second_start_edge", tog_b[4] - e0, 14);
    check("s3_valid0_edge", val_b[0] - e0, 13);
    check("s3_valid1_edge", val_b[1] - e0, 27);
    check("s3_dx0", dxq_b[0], 8'h81);
    check("s3_dy0", dyq_b[0], 8'h7E);
    check("s3_buttons0", btq_b[0], 2'b00);
    check("s3_dx1", dxq_b[1], 8'h2D);
    check("s3_dy1", dyq_b[1], 8'h4B);
    check("s3_buttons1", btq_b[1], 2'b01);
    check("s3_strobe_end", strobe_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=%0d exp=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/msx_mouse_reader.md
# msx_mouse_reader

Host-side MSX joystick-port mouse reader: the initiator that drives the port strobe line and collects the four-nibble mouse packet (X high, X low, Y high, Y low) from a strobe-driven responder such as `ps2mouse`. It runs in the `clk_sys` domain next to the joystick/mouse muxing in `emu`. It serves two purposes:
- a bench stimulus for mouse-protocol verification;
- a reader for an external mouse on the `USER_IN`/`USER_OUT` port.

Each `start` pulse produces one complete read, returning a signed 8-bit X delta, a signed 8-bit Y delta and the button state.

## Interface
Parameters:
- `SETTLE`, default 64: `clk_sys` cycles from a strobe toggle to the nibble sample. Legal range is 3..4095; 64 cycles is about 3 µs at 21.48 MHz.

Ports (clock and reset first):
- `clk_sys`  input  1  system clock; all logic is on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle request; accepted only while `busy`=0.
- `data`  input  6  port pins: [3:0] nibble, [5:4] buttons (active-low). Asynchronous to `clk_sys`.
- `strobe`  output  1  port strobe line (pin 8).
- `busy`  output  1  high from the accepting edge until the result edge.
- `valid`  output  1  one-cycle pulse when `dx`/`dy`/`buttons` are updated.
- `dx`  output  8  X delta, two's complement, {nibble0, nibble1}.
- `dy`  output  8  Y delta, two's complement, {nibble2, nibble3}.
- `buttons`  output  2  `~data[5:4]` sampled with nibble 3; 1 = pressed.

## Operation
- `data` passes through a 2-flop synchronizer before any use.
- States: IDLE, WAIT, DONE.
- **IDLE**
  - `busy`=0.
  - `start`=1 → toggle `strobe`, load counter = `SETTLE`-1, clear nibble index, set `busy`, go to WAIT.
- **WAIT**
  - The counter decrements each cycle.
  - At counter = 0, capture the synchronized `data[3:0]` into nibble[index].
  - If index < 3: toggle `strobe`, reload the counter, increment the index, stay in WAIT.
  - If index = 3: also capture `~data[5:4]`, then go to DONE.
- **DONE** (one cycle)
  - Load `dx`, `dy` and `buttons` from the nibble registers.
  - Pulse `valid`, clear `busy`, return to IDLE.
- Four toggles are made per read, so `strobe` returns to its pre-read level. The idle level after reset is 0.
- `start` while `busy`=1 is ignored; nothing is queued.
- `dx`/`dy`/`buttons` hold their last values between reads.
- Asynchronous reset mid-read:
  - state → IDLE immediately;
  - `strobe`=0, `busy`=0, `valid`=0;
  - `dx`=`dy`=0, `buttons`=0;
  - the partial packet is discarded.
  - The responder resynchronizes through its own strobe-idle timeout.
- No arithmetic is performed on the deltas: nibbles are concatenated as-is. Sign interpretation is the consumer's job; per the MSX convention a positive value means left/up.

## Timing
- Edge 0 = the edge at which `start` is sampled high in IDLE.
- Strobe toggle n (n = 0..3) occurs at edge n·`SETTLE`.
- Nibble n is sampled at edge (n+1)·`SETTLE`. The sampled value is the `data` pin state from about 2 cycles earlier, because of the synchronizer.
- `valid`=1 and the updated outputs are visible during the cycle after edge 4·`SETTLE`+1.
- `busy` is high from after edge 0 through edge 4·`SETTLE`+1.
- The earliest next `start` is accepted at edge 4·`SETTLE`+2, giving a period of 4·`SETTLE`+2 cycles.
- `SETTLE` < 3 is illegal: the synchronizer would return the pre-toggle nibble.
- The responder timeout must exceed `SETTLE` cycles.

## Structure
- `msx_mouse_pkg`:
  - `state_t` enum {IDLE, WAIT, DONE};
  - `nib_idx_t` (2 bits);
  - localparam `CNT_W` = $clog2(4096).
- Sub-module `sync_ff` (2-flop, parameterized width, async active-low reset to 0), instantiated once for `data`.
- Everything else stays in one always_ff plus small combinational next-state logic.

## Test plan
- Reset with `SETTLE`=64: all outputs are 0. `start` at edge 0 → `strobe` toggles at edges 0/64/128/192, `valid` pulses after edge 257, `busy` falls at the same edge, `strobe` ends at 0.
- Mouse model presents nibbles 0x0, 0x5, 0xF, 0xD with `data[5:4]`=2'b10 → `dx`=8'h05, `dy`=8'hFD, `buttons`=2'b01.
- Back-to-back: `start` held high continuously → reads begin at edges 0, 258, 516; no extra strobe toggles; each read returns fresh model values.
- `start` pulsed at edge 100 (busy) → ignored: still exactly 4 toggles and 1 `valid` for that read.
- `reset_n` asserted at edge 150 (after 2 nibbles) → `strobe`/`busy` go to 0 asynchronously and `dx`/`dy` = 0. After release, the model times out, and a new `start` yields a correct full packet.
- `SETTLE`=3 and `data` changing exactly at each toggle → all nibbles are captured correctly (checks synchronizer margin).
